// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes, opcode/funct
// values, mux selects and exception causes. Optional mult/div states exist only with MULTDIV_WAIT_EN.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_EXCEPT   = 4'd13
`ifdef MULTDIV_WAIT_EN
    ,
    ST_EXEC_MD  = 4'd14,
    ST_MD_WAIT  = 4'd15
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] SRCB_REGB    = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_IMM     = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;

  function automatic logic [2:0] funct_to_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier. mult/div functs are recognised only when
// MULTDIV_WAIT_EN is defined; otherwise they fall into is_invalid.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_r,
  output logic       is_addi,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_md,
  output logic       is_invalid
);

  always_comb begin
    is_r       = 1'b0;
    is_addi    = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_md      = 1'b0;
    is_invalid = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR: is_r = 1'b1;
`ifdef MULTDIV_WAIT_EN
          FN_MULT, FN_DIV:               is_md = 1'b1;
`endif
          default:                       is_invalid = 1'b1;
        endcase
      end
      OP_ADDI: is_addi    = 1'b1;
      OP_LW:   is_lw      = 1'b1;
      OP_SW:   is_sw      = 1'b1;
      OP_BEQ:  is_beq     = 1'b1;
      OP_J:    is_j       = 1'b1;
      default: is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Control FSM for the multicycle datapath (fetch/decode/execute/memory/writeback).
// Optional mult/div wait states are enabled by defining MULTDIV_WAIT_EN.
module multicycle_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       md_done,
  output logic [2:0] alu_src_b,
  output logic       alu_src_a,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic [1:0] exc_cause,
  output logic       md_start,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [1:0]       exc_cause_q, exc_cause_d;
  logic             lat_last;

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_md, is_invalid;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .is_r       (is_r),
    .is_addi    (is_addi),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_md      (is_md),
    .is_invalid (is_invalid)
  );

  assign lat_last  = (lat_cnt_q == LAT_LAST);
  assign exc_cause = exc_cause_q;
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      lat_cnt_q   <= '0;
      exc_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    exc_cause_d  = exc_cause_q;
    alu_src_b    = SRCB_REGB;
    alu_src_a    = 1'b0;
    alu_op       = ALU_ADD;
    pc_src       = PC_ALU;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    epc_write    = 1'b0;
`ifdef MULTDIV_WAIT_EN
    md_start     = 1'b0;
`endif
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (lat_last) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Speculatively compute the branch target while the opcode is classified.
        alu_src_b    = SRCB_IMM_SH2;
        aluout_write = 1'b1;
        if (is_r)                 state_d = ST_EXEC_R;
        else if (is_addi)         state_d = ST_EXEC_I;
        else if (is_lw || is_sw)  state_d = ST_MEM_ADDR;
        else if (is_beq)          state_d = ST_BRANCH;
        else if (is_j)            state_d = ST_JUMP;
`ifdef MULTDIV_WAIT_EN
        else if (is_md)           state_d = ST_EXEC_MD;
`endif
        else begin
          state_d     = ST_EXCEPT;
          exc_cause_d = CAUSE_INVALID;
        end
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_op       = funct_to_alu_op(funct);
        aluout_write = 1'b1;
        if (overflow && (funct == FN_ADD || funct == FN_SUB)) begin
          state_d     = ST_EXCEPT;
          exc_cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB_R;
        end
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        if (overflow) begin
          state_d     = ST_EXCEPT;
          exc_cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB_I;
        end
      end
      ST_WB_I: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        state_d      = is_lw ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_rd = 1'b1;
        if (lat_last) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_wr  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_EXCEPT: begin
        epc_write = 1'b1;
        pc_src    = PC_EXC;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
`ifdef MULTDIV_WAIT_EN
      ST_EXEC_MD: begin
        md_start = 1'b1;
        state_d  = ST_MD_WAIT;
      end
      ST_MD_WAIT: begin
        if (md_done) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_RESET;
    endcase

    // The latency counter only advances while a multi-cycle memory access is pending.
    if (state_d != state_q)
      lat_cnt_d = '0;
    else if (state_q == ST_FETCH || state_q == ST_MEM_RD)
      lat_cnt_d = lat_cnt_q + CNT_W'(1);
    else
      lat_cnt_d = lat_cnt_q;
  end

`ifndef MULTDIV_WAIT_EN
  logic unused_md;
  assign unused_md = ^{md_done, is_md};
  assign md_start  = 1'b0;
`endif

endmodule
